// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the floating-point compare/min/max unit: op encodings,
// operand width helper and canonical quiet-NaN construction.
package fp_cmp_pkg;

    localparam int FP_MAX_W = 128;

    typedef enum logic [1:0] {
        OP_CMP     = 2'b00,
        OP_MIN     = 2'b01,
        OP_MAX     = 2'b10,
        OP_CMP_ABS = 2'b11
    } fp_op_e;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Sign 0, exponent all ones, mantissa MSB set; callers truncate to their width.
    function automatic logic [FP_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_compare_unit_classify.sv
// Splits one IEEE-style operand into sign and magnitude and flags NaN / zero.
module fp_classify
    import fp_cmp_pkg::*;
#(
    parameter int  EXP_W = 5,
    parameter int  MAN_W = 10,
    localparam int W     = fp_width(EXP_W, MAN_W)
) (
    input  logic [W-1:0] val,
    output logic         is_nan,
    output logic         is_zero,
    output logic         sign,
    output logic [W-2:0] mag
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f   = val[W-2 -: EXP_W];
    assign man_f   = val[MAN_W-1:0];
    assign is_nan  = (&exp_f) & (|man_f);
    assign is_zero = ~|val[W-2:0];
    assign sign    = val[W-1];
    assign mag     = val[W-2:0];

endmodule

// File: rtl/fp_compare_unit.sv
// Two-stage pipelined floating-point compare/min/max with valid/ready on both sides.
// S1 holds operand classification and the ordering; S2 holds result and ALU flags.
module fp_compare_unit
    import fp_cmp_pkg::*;
#(
    parameter int  EXP_W = 5,
    parameter int  MAN_W = 10,
    localparam int W     = fp_width(EXP_W, MAN_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         negative,
    output logic         zero,
    output logic         overflow,
    output logic         cout,
    output logic         unordered
);

    localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));

    logic         x_nan, x_zero, x_sign;
    logic         y_nan, y_zero, y_sign;
    logic [W-2:0] x_mag, y_mag;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
        .val(x), .is_nan(x_nan), .is_zero(x_zero), .sign(x_sign), .mag(x_mag)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (
        .val(y), .is_nan(y_nan), .is_zero(y_zero), .sign(y_sign), .mag(y_mag)
    );

    logic mag_lt, mag_eq, both_zero;
    logic cmp_lt, cmp_eq;

    assign mag_lt    = x_mag < y_mag;
    assign mag_eq    = x_mag == y_mag;
    assign both_zero = x_zero & y_zero;

    // Two negatives order with magnitude reversed; +0 and -0 are equal.
    always_comb begin
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        if (op == OP_CMP_ABS) begin
            cmp_lt = mag_lt;
            cmp_eq = mag_eq;
        end else if (both_zero) begin
            cmp_eq = 1'b1;
        end else if (x_sign != y_sign) begin
            cmp_lt = x_sign;
        end else if (x_sign) begin
            cmp_lt = ~mag_lt & ~mag_eq;
            cmp_eq = mag_eq;
        end else begin
            cmp_lt = mag_lt;
            cmp_eq = mag_eq;
        end
    end

    logic         s1_valid, s2_valid;
    logic         s1_adv, s2_adv;
    fp_op_e       s1_op;
    logic [W-1:0] s1_x, s1_y;
    logic         s1_x_nan, s1_y_nan, s1_both_zero, s1_lt, s1_eq;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign overflow  = 1'b0;
    assign cout      = 1'b0;

    logic         s1_nan_any;
    logic [W-1:0] nxt_result;

    assign s1_nan_any = s1_x_nan | s1_y_nan;

    always_comb begin
        nxt_result = '0;
        if (s1_op == OP_MIN || s1_op == OP_MAX) begin
            if (s1_x_nan && s1_y_nan) begin
                nxt_result = QNAN;
            end else if (s1_x_nan) begin
                nxt_result = s1_y;
            end else if (s1_y_nan) begin
                nxt_result = s1_x;
            end else if (s1_both_zero) begin
                // MIN prefers the -0, MAX the +0
                nxt_result = ((s1_op == OP_MIN) == s1_x[W-1]) ? s1_x : s1_y;
            end else if (s1_eq) begin
                nxt_result = s1_x;
            end else begin
                nxt_result = ((s1_op == OP_MIN) == s1_lt) ? s1_x : s1_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_op        <= fp_op_e'(op);
            s1_x         <= x;
            s1_y         <= y;
            s1_x_nan     <= x_nan;
            s1_y_nan     <= y_nan;
            s1_both_zero <= both_zero;
            s1_lt        <= cmp_lt;
            s1_eq        <= cmp_eq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            unordered <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result    <= nxt_result;
                    negative  <= ~s1_nan_any & s1_lt;
                    zero      <= ~s1_nan_any & s1_eq;
                    unordered <= s1_nan_any;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_compare_unit.sv
// Scoreboard bench for fp_compare_unit: half-precision and single-precision instances
// checked against a value-ordering reference model.
module tb_fp_compare_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] x, y, result;
    logic [1:0]  op;
    logic        negative, zero, overflow, cout, unordered;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [31:0] x_w, y_w, result_w;
    logic [1:0]  op_w;
    logic        negative_w, zero_w, overflow_w, cout_w, unordered_w;

    fp_compare_unit u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .negative(negative), .zero(zero),
        .overflow(overflow), .cout(cout), .unordered(unordered)
    );

    fp_compare_unit #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .x(x_w), .y(y_w), .op(op_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .result(result_w), .negative(negative_w), .zero(zero_w),
        .overflow(overflow_w), .cout(cout_w), .unordered(unordered_w)
    );

    typedef struct packed {
        logic [63:0] res;
        logic        neg;
        logic        zer;
        logic        uno;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    function automatic exp_t mk(input logic [63:0] r, input logic n, input logic z, input logic u);
        exp_t e;
        e.res = r;
        e.neg = n;
        e.zer = z;
        e.uno = u;
        return e;
    endfunction

    // Maps each non-NaN operand to a signed integer key whose order is the real-number order.
    function automatic exp_t model(input int ew, input int mw, input logic [1:0] o,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        int          w;
        logic [63:0] emax, mmask, signbit, magmask, ea, eb, ma, mb, mga, mgb;
        logic        sa, sb, anan, bnan, lt, eq;
        longint      ka, kb;
        w       = 1 + ew + mw;
        emax    = (64'd1 << ew) - 64'd1;
        mmask   = (64'd1 << mw) - 64'd1;
        signbit = 64'd1 << (w - 1);
        magmask = signbit - 64'd1;
        ea = (a >> mw) & emax;
        eb = (b >> mw) & emax;
        ma = a & mmask;
        mb = b & mmask;
        sa = (a & signbit) != 0;
        sb = (b & signbit) != 0;
        mga = a & magmask;
        mgb = b & magmask;
        anan = (ea == emax) && (ma != 0);
        bnan = (eb == emax) && (mb != 0);
        ka = (o == 2'b11 || !sa) ? longint'(mga) : -longint'(mga);
        kb = (o == 2'b11 || !sb) ? longint'(mgb) : -longint'(mgb);
        lt = ka < kb;
        eq = ka == kb;
        e.uno = anan || bnan;
        e.neg = !e.uno && lt;
        e.zer = !e.uno && eq;
        e.res = 64'd0;
        if (o == 2'b01 || o == 2'b10) begin
            if (anan && bnan)                e.res = (emax << mw) | (64'd1 << (mw - 1));
            else if (anan)                   e.res = b;
            else if (bnan)                   e.res = a;
            else if (mga == 0 && mgb == 0)  e.res = (o == 2'b01) ? ((sa || sb) ? signbit : 64'd0)
                                                                  : ((sa && sb) ? signbit : 64'd0);
            else if (eq)                     e.res = a;
            else if (o == 2'b01)             e.res = lt ? a : b;
            else                             e.res = lt ? b : a;
        end
        return e;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'h8000;
            2: v = {v[15], 5'h1F, 10'h000};
            3: v = {v[15], 5'h1F, 10'($urandom_range(1, 1023))};
            4: v = {v[15], 5'h00, v[9:0]};
            5: v = {v[15], 5'h0F, v[9:0]};
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rnd32();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 6))
            0: v = {v[31], 31'h0};
            1: v = {v[31], 8'hFF, 23'h0};
            2: v = {v[31], 8'hFF, 23'($urandom_range(1, 8388607))};
            3: v = {v[31], 8'h00, v[22:0]};
            4: v = {v[31], 8'h7F, v[22:0]};
            default: ;
        endcase
        return v;
    endfunction

    task automatic send16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        op = o;
        x = a;
        y = b;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q16.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                break;
            end
            n++;
            if (n > 200) begin
                fail_now("send16_timeout");
                in_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send16m(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        send16(o, a, b, model(5, 10, o, {48'd0, a}, {48'd0, b}));
    endtask

    task automatic send32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int n;
        n = 0;
        in_valid_w = 1'b1;
        op_w = o;
        x_w = a;
        y_w = b;
        forever begin
            @(negedge clk);
            if (in_ready_w) begin
                q32.push_back(e);
                @(posedge clk);
                #1;
                in_valid_w = 1'b0;
                break;
            end
            n++;
            if (n > 200) begin
                fail_now("send32_timeout");
                in_valid_w = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q16.size() > 0 || q32.size() > 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q16.size() > 0 || q32.size() > 0) fail_now(name);
    endtask

    // Monitor for the half-precision instance, including hold-while-stalled checks.
    initial begin
        exp_t        e;
        logic        stalled;
        logic [18:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("hold16", {result, negative, zero, unordered}, held);
                if (out_valid && out_ready) begin
                    if (q16.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected16 actual=%h required=none", result);
                    end else begin
                        e = q16.pop_front();
                        check("res16", result, e.res);
                        check("flags16", {negative, zero, unordered}, {e.neg, e.zer, e.uno});
                        check("ovf_cout16", {overflow, cout}, 2'b00);
                    end
                end
                stalled = out_valid && !out_ready;
                held    = {result, negative, zero, unordered};
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid_w && out_ready_w) begin
                if (q32.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected32 actual=%h required=none", result_w);
                end else begin
                    e = q32.pop_front();
                    check("res32", result_w, e.res);
                    check("flags32", {negative_w, zero_w, unordered_w}, {e.neg, e.zer, e.uno});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        saw_block, rnd_done;
        logic [15:0] a, b;
        logic [1:0]  o;
        logic [31:0] a32, b32;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; op = '0;
        in_valid_w = 1'b0; out_ready_w = 1'b1; x_w = '0; y_w = '0; op_w = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_result", result, 16'h0000);
        check("rst_flags", {negative, zero, overflow, cout, unordered}, 5'b0);
        check("rst_out_valid32", out_valid_w, 1'b0);
        @(posedge clk);
        #1;

        // Latency: transfer at one edge, out_valid two edges later.
        in_valid = 1'b1; op = 2'b00; x = 16'h3C00; y = 16'h4000;
        q16.push_back(mk(64'h0, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("latency_1", out_valid, 1'b0);
        @(negedge clk);
        check("latency_2", out_valid, 1'b1);
        @(posedge clk);
        #1;

        send16(2'b00, 16'h4000, 16'h3C00, mk(64'h0,    1'b0, 1'b0, 1'b0));
        send16(2'b00, 16'h8000, 16'h0000, mk(64'h0,    1'b0, 1'b1, 1'b0));
        send16(2'b01, 16'h8000, 16'h0000, mk(64'h8000, 1'b0, 1'b1, 1'b0));
        send16(2'b10, 16'h8000, 16'h0000, mk(64'h0000, 1'b0, 1'b1, 1'b0));
        send16(2'b01, 16'h0000, 16'h8000, mk(64'h8000, 1'b0, 1'b1, 1'b0));
        send16(2'b10, 16'h0000, 16'h8000, mk(64'h0000, 1'b0, 1'b1, 1'b0));
        send16(2'b11, 16'hBC00, 16'h3C00, mk(64'h0,    1'b0, 1'b1, 1'b0));
        send16(2'b00, 16'h7E00, 16'hC000, mk(64'h0,    1'b0, 1'b0, 1'b1));
        send16(2'b10, 16'h7E00, 16'hC000, mk(64'hC000, 1'b0, 1'b0, 1'b1));
        send16(2'b10, 16'h7C01, 16'h7E00, mk(64'h7E00, 1'b0, 1'b0, 1'b1));
        send16(2'b00, 16'hC000, 16'hBC00, mk(64'h0,    1'b1, 1'b0, 1'b0));
        send16(2'b01, 16'hC000, 16'hBC00, mk(64'hC000, 1'b1, 1'b0, 1'b0));
        send16(2'b11, 16'hC000, 16'hBC00, mk(64'h0,    1'b0, 1'b0, 1'b0));
        send16(2'b00, 16'h0001, 16'h0002, mk(64'h0,    1'b1, 1'b0, 1'b0));
        drain("drain_directed");

        // Burst of 8 with the consumer stalled on cycles 3-6.
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = rnd16();
                    b = rnd16();
                    o = 2'($urandom_range(0, 3));
                    send16m(o, a, b);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                repeat (12) begin
                    @(negedge clk);
                    if (!in_ready) saw_block = 1'b1;
                end
            end
        join
        check("burst_in_ready_drop", saw_block, 1'b1);
        drain("drain_burst");

        // Random traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    a = rnd16();
                    case ($urandom_range(0, 5))
                        0: b = a;
                        1: b = a ^ 16'h8000;
                        default: b = rnd16();
                    endcase
                    o = 2'($urandom_range(0, 3));
                    send16m(o, a, b);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        // Reset with two operations in flight.
        out_ready = 1'b0;
        send16m(2'b01, 16'h3C00, 16'h4000);
        send16m(2'b10, 16'h3C00, 16'h4000);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q16.delete();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_stale", q16.size(), 0);

        // Single-precision instance.
        send32(2'b01, 32'hBF800000, 32'h3F800000, mk(64'hBF800000, 1'b1, 1'b0, 1'b0));
        send32(2'b10, 32'hBF800000, 32'h3F800000, mk(64'h3F800000, 1'b1, 1'b0, 1'b0));
        send32(2'b10, 32'h7F800001, 32'hFFC00000, mk(64'h7FC00000, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 60; i++) begin
            a32 = rnd32();
            b32 = ($urandom_range(0, 4) == 0) ? (a32 ^ 32'h80000000) : rnd32();
            o = 2'($urandom_range(0, 3));
            send32(o, a32, b32, model(8, 23, o, {32'd0, a32}, {32'd0, b32}));
        end
        drain("drain_32");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
